reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of DAC synth/ramp channels (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop stages on each asynchronous input (2..4).
REQ-003 SHALL have parameter WD_TIMEOUT_CYCLES, default 12500000, max cycles between watchdog edges (100 ms at 125 MHz).
REQ-004 SHALL have parameters ALIVE_LOW_CYCLES, default 12500000, and ALIVE_HIGH_CYCLES, default 1250000, alive-pulse low/high times.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock; peripheral_aresetn  in  1  async active-low reset.
REQ-006 SHALL have cfg  in  8  control bits: [0] trigger mode, [1] watchdog enable, [2] sata propagate, [3] instant-reset enable, [4] external trigger select, [5] internal trigger enable, [6] keep-alive release.
REQ-007 SHALL have is_master  in  1; counter_trigger  in  1; sata_trigger  in  1; ext_trigger  in  1 (async); watchdog_in  in  1 (async heartbeat); instant_reset_in  in  1 (async).
REQ-008 SHALL have ramp_en  in  NUM_CH; ramp_down_req  in  NUM_CH; ramp_done  in  NUM_CH (ramp generator reports output at zero).
REQ-009 SHALL have ram_writer_aresetn  out  1; synth_aresetn  out  NUM_CH; start_ramp_down  out  NUM_CH; output_on  out  NUM_CH; keep_alive_aresetn  out  1.
REQ-010 SHALL have sata_out, master_trigger_out, alive_out, reset_ack_out  out  1 each; status  out  32.

Function
REQ-011 SHALL pass ext_trigger, watchdog_in, instant_reset_in through SYNC_STAGES synchronisers; all logic uses synced copies only.
REQ-012 trig SHALL be registered: cfg[4]=1 -> synced ext_trigger; else (cfg[5] & counter_trigger) | (~is_master & sata_trigger registered once).
REQ-013 master_trigger_out SHALL equal cfg[5] & counter_trigger delayed 2 cycles; sata_out SHALL equal trig & cfg[2].
REQ-014 cfg[0]=0 (continuous): ram_writer_aresetn and all synth_aresetn SHALL be 1 one cycle after reset release, channel FSMs held in RUN.
REQ-015 cfg[0]=1: ram_writer_aresetn SHALL follow trig with 1-cycle latency.
REQ-016 Per channel FSM SHALL have states IDLE, RUN, RAMP, HOLD.
REQ-017 IDLE->RUN when trig=1 and no abort; synth_aresetn[i]=1, output_on[i]=1 in RUN.
REQ-018 RUN->RAMP on abort (instant_reset & cfg[3], or watchdog fault) or ramp_down_req[i]; if ramp_en[i]=0, RUN->HOLD directly with synth_aresetn[i]=0 next cycle.
REQ-019 In RAMP: start_ramp_down[i]=1, synth_aresetn[i]=1; ->HOLD on ramp_done[i]=1.
REQ-020 In HOLD: synth_aresetn[i]=0, output_on[i]=0; ->IDLE when trig=0 and abort=0.
REQ-021 RUN->IDLE when trig falls with no abort; IDLE holds synth_aresetn[i]=0.
REQ-022 Abort and trig fall in same cycle: abort SHALL win (->RAMP).
REQ-023 Watchdog counter (17..28 bits, sized from WD_TIMEOUT_CYCLES) SHALL clear on any synced watchdog_in edge; saturates; fault when count = WD_TIMEOUT_CYCLES and cfg[1]=1 and cfg[0]=1.
REQ-024 Fault SHALL be sticky until trig=0 and all channels in IDLE or HOLD; reset_ack_out = fault | (instant_reset & cfg[3]).
REQ-025 alive_out SHALL be 0 for ALIVE_LOW_CYCLES then 1 for ALIVE_HIGH_CYCLES, period wrapping exactly.
REQ-026 keep_alive_aresetn SHALL equal cfg[6] registered.
REQ-027 status: [0] reset released, [1] fault, [2] trig, [3] ram_writer_aresetn, [7:4] synced ext/wd/instant/sata, [15:8] output_on zero-extended, [31:16] per-channel 2-bit state, zero-extended.

Reset
REQ-028 On peripheral_aresetn=0: all FSMs IDLE, all *_aresetn=0, output_on=0, start_ramp_down=0, fault=0, counters=0, alive_out=0, reset_ack_out=0.
REQ-029 Reset asserted mid-RAMP SHALL force IDLE immediately without waiting for ramp_done.

Configuration
REQ-030 RESET_SEQ_WATCHDOG_EN defined: REQ-023/024 watchdog logic present. Undefined: counter removed, fault constant 0, status[1]=0, reset_ack_out = instant_reset & cfg[3].

Structure
REQ-031 reset_seq_pkg SHALL hold state enum (IDLE=0,RUN=1,RAMP=2,HOLD=3) and cfg bit-index constants.
REQ-032 Sub-module reset_seq_channel SHALL implement one channel FSM, instantiated NUM_CH times via generate.

Verification
REQ-033 cfg=0x00, release reset -> synth_aresetn=all 1, ram_writer_aresetn=1 after 1 cycle.
REQ-034 cfg=0x21, counter_trigger 0->1 -> ram_writer_aresetn=1 one cycle after trig; channels RUN, output_on=2'b11.
REQ-035 cfg=0x29, ramp_en=2'b01, pulse instant_reset_in during RUN -> ch0 RAMP (start_ramp_down[0]=1) until ramp_done[0], ch1 HOLD next cycle; both IDLE after trig=0.
REQ-036 cfg=0x23, WD_TIMEOUT_CYCLES=100, stop watchdog toggles -> fault and reset_ack_out=1 at cycle 100; clears after trig=0 and channels HOLD.
REQ-037 RAMP in progress, peripheral_aresetn=0 -> all outputs at reset values same cycle; ALIVE_LOW/HIGH=8/2 -> alive_out period 10.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: channel state encoding, cfg bit indices
// and the helper that sizes the watchdog counter.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_RAMP = 2'd2,
    CH_HOLD = 2'd3
  } ch_state_e;

  localparam int CFG_TRIG_MODE  = 0;
  localparam int CFG_WD_EN      = 1;
  localparam int CFG_SATA_PROP  = 2;
  localparam int CFG_INST_EN    = 3;
  localparam int CFG_EXT_SEL    = 4;
  localparam int CFG_INT_TRIG   = 5;
  localparam int CFG_KEEP_ALIVE = 6;

  // Watchdog counter width, clamped to the 17..28 bit range.
  function automatic int wd_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 17) w = 17;
    if (w > 28) w = 28;
    return w;
  endfunction

endpackage

// File: rtl/reset_seq_channel.sv
// One DAC synth/ramp channel sequencer; outputs are decoded from the registered state.
//   state | meaning
//   IDLE  | synth held in reset, output off, waiting for trig
//   RUN   | synth released, output on
//   RAMP  | ramp-down requested, waiting for ramp_done
//   HOLD  | synth in reset, output off, waiting for trig=0 and no abort
module reset_seq_channel
  import reset_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       trig,
  input  logic       abort,
  input  logic       ramp_en,
  input  logic       ramp_down_req,
  input  logic       ramp_done,
  output logic       synth_aresetn,
  output logic       start_ramp_down,
  output logic       output_on,
  output logic [1:0] state,
  output logic       parked
);

  localparam logic [1:0] ST_IDLE = CH_IDLE;
  localparam logic [1:0] ST_RUN  = CH_RUN;
  localparam logic [1:0] ST_RAMP = CH_RAMP;
  localparam logic [1:0] ST_HOLD = CH_HOLD;

  logic [1:0] state_nxt;

  always_comb begin
    state_nxt = state;
    if (!mode) begin
      // continuous mode keeps every channel running
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_IDLE: if (trig && !abort) state_nxt = ST_RUN;
        ST_RUN: begin
          if (abort || ramp_down_req) state_nxt = ramp_en ? ST_RAMP : ST_HOLD;
          else if (!trig)             state_nxt = ST_IDLE;
        end
        ST_RAMP: if (ramp_done) state_nxt = ST_HOLD;
        ST_HOLD: if (!trig && !abort) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  assign synth_aresetn   = (state == ST_RUN) || (state == ST_RAMP);
  assign output_on       = (state == ST_RUN) || (state == ST_RAMP);
  assign start_ramp_down = (state == ST_RAMP);
  assign parked          = (state == ST_IDLE) || (state == ST_HOLD);

endmodule

// File: rtl/reset_sequencer.sv
// Reset/trigger sequencer for RAM writer and DAC channels with alive pulse and status word.
// Optional watchdog fault logic is built only when RESET_SEQ_WATCHDOG_EN is defined.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH            = 2,
  parameter int SYNC_STAGES       = 2,
  parameter int WD_TIMEOUT_CYCLES = 12500000,
  parameter int ALIVE_LOW_CYCLES  = 12500000,
  parameter int ALIVE_HIGH_CYCLES = 1250000
) (
  input  logic              clk,
  input  logic              peripheral_aresetn,
  input  logic [7:0]        cfg,
  input  logic              is_master,
  input  logic              counter_trigger,
  input  logic              sata_trigger,
  input  logic              ext_trigger,
  input  logic              watchdog_in,
  input  logic              instant_reset_in,
  input  logic [NUM_CH-1:0] ramp_en,
  input  logic [NUM_CH-1:0] ramp_down_req,
  input  logic [NUM_CH-1:0] ramp_done,
  output logic              ram_writer_aresetn,
  output logic [NUM_CH-1:0] synth_aresetn,
  output logic [NUM_CH-1:0] start_ramp_down,
  output logic [NUM_CH-1:0] output_on,
  output logic              keep_alive_aresetn,
  output logic              sata_out,
  output logic              master_trigger_out,
  output logic              alive_out,
  output logic              reset_ack_out,
  output logic [31:0]       status
);

  localparam int ALIVE_PERIOD = ALIVE_LOW_CYCLES + ALIVE_HIGH_CYCLES;
  localparam int ALIVE_W      = (ALIVE_PERIOD > 2) ? $clog2(ALIVE_PERIOD) : 1;

  logic [SYNC_STAGES-1:0] ext_sync, wd_sync, inst_sync;
  logic                   ext_s, wd_s, inst_s;
  logic                   sata_q, trig, released, fault, abort;
  logic [1:0]             mt_pipe;
  logic [ALIVE_W-1:0]     alive_cnt, alive_cnt_nxt;
  logic [NUM_CH-1:0]      parked;
  logic [1:0]             ch_state [NUM_CH];
  logic                   unused_cfg;

  assign ext_s  = ext_sync[SYNC_STAGES-1];
  assign wd_s   = wd_sync[SYNC_STAGES-1];
  assign inst_s = inst_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      ext_sync           <= '0;
      wd_sync            <= '0;
      inst_sync          <= '0;
      sata_q             <= 1'b0;
      trig               <= 1'b0;
      mt_pipe            <= 2'b00;
      released           <= 1'b0;
      ram_writer_aresetn <= 1'b0;
      keep_alive_aresetn <= 1'b0;
    end else begin
      ext_sync           <= {ext_sync[SYNC_STAGES-2:0], ext_trigger};
      wd_sync            <= {wd_sync[SYNC_STAGES-2:0], watchdog_in};
      inst_sync          <= {inst_sync[SYNC_STAGES-2:0], instant_reset_in};
      sata_q             <= sata_trigger;
      trig               <= cfg[CFG_EXT_SEL] ? ext_s
                            : ((cfg[CFG_INT_TRIG] & counter_trigger) | (~is_master & sata_q));
      mt_pipe            <= {mt_pipe[0], cfg[CFG_INT_TRIG] & counter_trigger};
      released           <= 1'b1;
      ram_writer_aresetn <= cfg[CFG_TRIG_MODE] ? trig : 1'b1;
      keep_alive_aresetn <= cfg[CFG_KEEP_ALIVE];
    end
  end

  assign master_trigger_out = mt_pipe[1];
  assign sata_out           = trig & cfg[CFG_SATA_PROP];
  assign abort              = (inst_s & cfg[CFG_INST_EN]) | fault;
  assign reset_ack_out      = fault | (inst_s & cfg[CFG_INST_EN]);

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int             WD_W     = wd_width(WD_TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_prev, wd_edge, fault_clr;

  assign wd_edge   = wd_s ^ wd_prev;
  // restarting the count on clear gives the heartbeat a fresh full timeout
  assign fault_clr = fault & ~trig & (&parked);

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      wd_cnt  <= '0;
      wd_prev <= 1'b0;
      fault   <= 1'b0;
    end else begin
      wd_prev <= wd_s;
      if (wd_edge || fault_clr)  wd_cnt <= '0;
      else if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + WD_W'(1);
      if (fault_clr)
        fault <= 1'b0;
      else if ((wd_cnt == WD_LIMIT) && cfg[CFG_WD_EN] && cfg[CFG_TRIG_MODE])
        fault <= 1'b1;
    end
  end

  assign unused_cfg = cfg[7];
`else
  localparam int unused_wd_timeout = WD_TIMEOUT_CYCLES;

  assign fault      = 1'b0;
  assign unused_cfg = cfg[7] ^ cfg[CFG_WD_EN];
`endif

  assign alive_cnt_nxt = (alive_cnt == ALIVE_W'(ALIVE_PERIOD - 1)) ? '0 : alive_cnt + ALIVE_W'(1);

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      alive_cnt <= '0;
      alive_out <= 1'b0;
    end else begin
      alive_cnt <= alive_cnt_nxt;
      alive_out <= (alive_cnt_nxt >= ALIVE_W'(ALIVE_LOW_CYCLES));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    reset_seq_channel u_ch (
      .clk             (clk),
      .rst_n           (peripheral_aresetn),
      .mode            (cfg[CFG_TRIG_MODE]),
      .trig            (trig),
      .abort           (abort),
      .ramp_en         (ramp_en[i]),
      .ramp_down_req   (ramp_down_req[i]),
      .ramp_done       (ramp_done[i]),
      .synth_aresetn   (synth_aresetn[i]),
      .start_ramp_down (start_ramp_down[i]),
      .output_on       (output_on[i]),
      .state           (ch_state[i]),
      .parked          (parked[i])
    );
  end

  always_comb begin
    status    = '0;
    status[0] = released;
    status[1] = fault;
    status[2] = trig;
    status[3] = ram_writer_aresetn;
    status[4] = ext_s;
    status[5] = wd_s;
    status[6] = inst_s;
    status[7] = sata_q;
    for (int i = 0; i < NUM_CH; i++) begin
      status[8 + i]        = output_on[i];
      status[16 + 2*i +: 2] = ch_state[i];
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus randomized stimulus
// compared every cycle against a behavioural model.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int NUM_CH = 2;
  localparam int SYNC   = 2;
  localparam int WD_T   = 100;
  localparam int A_LOW  = 8;
  localparam int A_HIGH = 2;

  logic              clk = 1'b0;
  logic              peripheral_aresetn = 1'b0;
  logic [7:0]        cfg = 8'h00;
  logic              is_master = 1'b1;
  logic              counter_trigger = 1'b0;
  logic              sata_trigger = 1'b0;
  logic              ext_trigger = 1'b0;
  logic              watchdog_in = 1'b0;
  logic              instant_reset_in = 1'b0;
  logic [NUM_CH-1:0] ramp_en = '0;
  logic [NUM_CH-1:0] ramp_down_req = '0;
  logic [NUM_CH-1:0] ramp_done = '0;
  logic              ram_writer_aresetn;
  logic [NUM_CH-1:0] synth_aresetn;
  logic [NUM_CH-1:0] start_ramp_down;
  logic [NUM_CH-1:0] output_on;
  logic              keep_alive_aresetn;
  logic              sata_out;
  logic              master_trigger_out;
  logic              alive_out;
  logic              reset_ack_out;
  logic [31:0]       status;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .WD_TIMEOUT_CYCLES(WD_T),
    .ALIVE_LOW_CYCLES(A_LOW), .ALIVE_HIGH_CYCLES(A_HIGH)
  ) dut (
    .clk(clk), .peripheral_aresetn(peripheral_aresetn), .cfg(cfg),
    .is_master(is_master), .counter_trigger(counter_trigger),
    .sata_trigger(sata_trigger), .ext_trigger(ext_trigger),
    .watchdog_in(watchdog_in), .instant_reset_in(instant_reset_in),
    .ramp_en(ramp_en), .ramp_down_req(ramp_down_req), .ramp_done(ramp_done),
    .ram_writer_aresetn(ram_writer_aresetn), .synth_aresetn(synth_aresetn),
    .start_ramp_down(start_ramp_down), .output_on(output_on),
    .keep_alive_aresetn(keep_alive_aresetn), .sata_out(sata_out),
    .master_trigger_out(master_trigger_out), .alive_out(alive_out),
    .reset_ack_out(reset_ack_out), .status(status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model; phase codes: 0 idle, 1 run, 2 ramp, 3 hold
  bit            m_rel, m_trig, m_rw, m_ka, m_sata_q;
  bit [SYNC-1:0] m_ext, m_wd, m_inst;
  bit [1:0]      m_mt;
  int            m_ph [NUM_CH];
  int            m_edges;
  bit            model_on = 1'b1;

  function automatic int next_phase(int ph, bit mode, bit trig, bit abort,
                                    bit ren, bit req, bit done);
    if (!mode) return 1;
    case (ph)
      0:       return (trig && !abort) ? 1 : 0;
      1:       if (abort || req) return ren ? 2 : 3;
               else return trig ? 1 : 0;
      2:       return done ? 3 : 2;
      default: return (!trig && !abort) ? 0 : 3;
    endcase
  endfunction

  task automatic model_reset();
    m_rel = 0; m_trig = 0; m_rw = 0; m_ka = 0; m_sata_q = 0;
    m_ext = '0; m_wd = '0; m_inst = '0; m_mt = '0; m_edges = 0;
    for (int i = 0; i < NUM_CH; i++) m_ph[i] = 0;
  endtask

  task automatic model_step();
    bit ext_s, abort, trig_old;
    if (!peripheral_aresetn) return;
    ext_s    = m_ext[SYNC-1];
    abort    = m_inst[SYNC-1] & cfg[3];
    trig_old = m_trig;
    for (int i = 0; i < NUM_CH; i++)
      m_ph[i] = next_phase(m_ph[i], cfg[0], trig_old, abort,
                           ramp_en[i], ramp_down_req[i], ramp_done[i]);
    m_rw     = cfg[0] ? trig_old : 1'b1;
    m_trig   = cfg[4] ? ext_s : ((cfg[5] & counter_trigger) | (!is_master & m_sata_q));
    m_mt     = {m_mt[0], cfg[5] & counter_trigger};
    m_sata_q = sata_trigger;
    m_ka     = cfg[6];
    m_rel    = 1;
    m_edges++;
    m_ext    = {m_ext[SYNC-2:0], ext_trigger};
    m_wd     = {m_wd[SYNC-2:0], watchdog_in};
    m_inst   = {m_inst[SYNC-2:0], instant_reset_in};
  endtask

  task automatic check_all();
    logic [NUM_CH-1:0] e_on, e_srd;
    logic [31:0]       e_st;
    e_st = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      e_on[i]               = (m_ph[i] == 1) || (m_ph[i] == 2);
      e_srd[i]              = (m_ph[i] == 2);
      e_st[8 + i]           = e_on[i];
      e_st[16 + 2*i +: 2]   = 2'(m_ph[i]);
    end
    e_st[0] = m_rel;  e_st[2] = m_trig;        e_st[3] = m_rw;
    e_st[4] = m_ext[SYNC-1]; e_st[5] = m_wd[SYNC-1];
    e_st[6] = m_inst[SYNC-1]; e_st[7] = m_sata_q;
    check("synth_aresetn", synth_aresetn, e_on);
    check("output_on", output_on, e_on);
    check("start_ramp_down", start_ramp_down, e_srd);
    check("ram_writer", ram_writer_aresetn, m_rw);
    check("master_trig", master_trigger_out, m_mt[1]);
    check("sata_out", sata_out, m_trig & cfg[2]);
    check("reset_ack", reset_ack_out, m_inst[SYNC-1] & cfg[3]);
    check("alive", alive_out, m_rel && ((m_edges % (A_LOW + A_HIGH)) >= A_LOW));
    check("keep_alive", keep_alive_aresetn, m_ka);
    check("status", status, e_st);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      if (model_on) check_all();
    end
  endtask

  task automatic async_reset();
    peripheral_aresetn = 1'b0;
    model_reset();
    #1;
    if (model_on) check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  initial begin
    int n, hi;
    model_reset();
    tick(3);
    check("rst_synth", synth_aresetn, 0);
    check("rst_rw", ram_writer_aresetn, 0);
    check("rst_status", status, 0);
    check("rst_alive", alive_out, 0);
    check("rst_ack", reset_ack_out, 0);

    // continuous mode after release
    cfg = 8'h00;
    peripheral_aresetn = 1'b1;
    tick();
    check("cont_synth", synth_aresetn, 2'b11);
    check("cont_rw", ram_writer_aresetn, 1);
    tick(5);

    // triggered mode via internal counter trigger
    cfg = 8'h21;
    tick(3);
    counter_trigger = 1'b1;
    n = 0;
    while (!ram_writer_aresetn && n < 10) begin tick(); n++; end
    check("trig_rw_latency", n, 2);
    check("trig_output_on", output_on, 2'b11);

    // instant reset: ch0 ramps, ch1 holds at once
    cfg = 8'h29; ramp_en = 2'b01;
    tick(2);
    instant_reset_in = 1'b1; tick(); instant_reset_in = 1'b0;
    n = 0;
    while (!start_ramp_down[0] && n < 10) begin tick(); n++; end
    check("abort_srd", start_ramp_down, 2'b01);
    check("abort_ch1_hold", status[19:18], 3);
    check("abort_ch1_synth", synth_aresetn[1], 0);
    tick(3);
    check("ramp_wait_srd", start_ramp_down, 2'b01);
    ramp_done = 2'b01; tick(); ramp_done = 2'b00;
    check("ramp_done_hold", status[17:16], 3);
    counter_trigger = 1'b0;
    n = 0;
    while (status[31:16] != 0 && n < 10) begin tick(); n++; end
    check("both_idle", status[31:16], 0);

    // reset asserted in the middle of a ramp
    counter_trigger = 1'b1;
    n = 0;
    while (output_on != 2'b11 && n < 10) begin tick(); n++; end
    check("rerun_on", output_on, 2'b11);
    instant_reset_in = 1'b1; tick(); instant_reset_in = 1'b0;
    n = 0;
    while (!start_ramp_down[0] && n < 10) begin tick(); n++; end
    check("pre_rst_ramp", start_ramp_down[0], 1);
    async_reset();
    check("midramp_srd", start_ramp_down, 0);
    check("midramp_synth", synth_aresetn, 0);
    check("midramp_on", output_on, 0);
    check("midramp_state", status[31:16], 0);
    tick(2);
    peripheral_aresetn = 1'b1;
    hi = 0;
    repeat (20) begin tick(); hi += int'(alive_out); end
    check("alive_high_cycles", hi, 2 * A_HIGH);

    // watchdog
    model_on = 1'b0;
    async_reset();
    tick(2);
    cfg = 8'h23; ramp_en = 2'b00; counter_trigger = 1'b1;
    peripheral_aresetn = 1'b1;
    repeat (6) begin tick(10); watchdog_in = ~watchdog_in; end
`ifdef RESET_SEQ_WATCHDOG_EN
    check("wd_no_fault", reset_ack_out, 0);
    n = 0;
    while (!reset_ack_out && n < 300) begin tick(); n++; end
    check("wd_not_early", n >= WD_T, 1);
    check("wd_not_late", n <= WD_T + SYNC + 3, 1);
    check("wd_status_fault", status[1], 1);
    tick();
    check("wd_hold", status[31:16], 16'h000F);
    counter_trigger = 1'b0;
    n = 0;
    while (reset_ack_out && n < 20) begin tick(); n++; end
    check("wd_cleared", reset_ack_out, 0);
    tick(2);
    check("wd_idle", status[31:16], 0);
`else
    tick(150);
    check("wd_off_ack", reset_ack_out, 0);
    check("wd_off_fault", status[1], 0);
    check("wd_off_run", output_on, 2'b11);
`endif
    peripheral_aresetn = 1'b0;
    model_reset();
    tick(2);
    model_on = 1'b1;
    counter_trigger = 1'b0; watchdog_in = 1'b0;
    peripheral_aresetn = 1'b1;

    // randomized traffic, watchdog disabled
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (cyc % 150 == 0) begin
        cfg       = 8'($urandom) & 8'h7D;
        cfg[0]    = ($urandom_range(0, 3) != 0);
        is_master = 1'($urandom_range(0, 1));
        ramp_en   = NUM_CH'($urandom);
      end
      if ($urandom_range(0, 7) == 0) counter_trigger = ~counter_trigger;
      if ($urandom_range(0, 9) == 0) ext_trigger = ~ext_trigger;
      if ($urandom_range(0, 9) == 0) sata_trigger = ~sata_trigger;
      if ($urandom_range(0, 9) == 0) watchdog_in = ~watchdog_in;
      instant_reset_in = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        ramp_down_req[i] = ($urandom_range(0, 15) == 0);
        ramp_done[i]     = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
        tick(2);
        peripheral_aresetn = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
